vga_fill_ctrl: RTL

Hardware rectangle-fill engine and write-port arbiter for the 80x60 VGA framebuffer.
- The CPU configures origin, size and colour through MMIO, then issues START.
- The engine then writes one pixel per cycle in raster order.
- Direct CPU pixel writes share the same framebuffer write port and always take priority.
- Sits between the IOBUS decode logic and the framebuffer driver's WA/WD/WE port.

---
 rtl/vga_fill_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_fill_ctrl.sv
// -----------------------------------------------------------------------------
// vga_fill_ctrl
// Rectangle-fill engine and write-port arbiter for the 80x60 VGA framebuffer.
// The CPU programs origin, size and colour over MMIO and issues START. The
// engine then emits one pixel per cycle in raster order. Direct CPU pixel
// writes share the framebuffer write port and always win; the engine stalls
// on those cycles, so no pixel is lost or duplicated.
//
// Ports
//   CLK, RESET_N            system clock, asynchronous active-low reset
//   CFG_WE/CFG_SEL/CFG_WD   config write: 0=ORIGIN 1=SIZE 2=COLOR 3=CMD
//                           (CMD: bit0=START, bit1=ABORT)
//   CPU_WE/CPU_WA/CPU_WD    direct CPU pixel write, address {row,col}
//   FB_WE/FB_WA/FB_WD       registered framebuffer write port
//   BUSY                    fill in progress
//   DONE / ERR              sticky status of the last START
//   DONE_PULSE              one-cycle completion pulse
// -----------------------------------------------------------------------------
module vga_fill_ctrl #(
  parameter int H_PIX = 80,
  parameter int V_PIX = 60,
  parameter int COL_W = 7,
  parameter int ROW_W = 6
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   CFG_WE,
  input  logic [1:0]             CFG_SEL,
  input  logic [31:0]            CFG_WD,
  input  logic                   CPU_WE,
  input  logic [ROW_W+COL_W-1:0] CPU_WA,
  input  logic [7:0]             CPU_WD,
  output logic                   FB_WE,
  output logic [ROW_W+COL_W-1:0] FB_WA,
  output logic [7:0]             FB_WD,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   DONE_PULSE
);

  localparam int AW = ROW_W + COL_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [7:0] H_LIM = 8'(H_PIX);
  localparam logic [7:0] V_LIM = 8'(V_PIX);

  logic [0:0]       state_q, state_d;
  logic [COL_W-1:0] x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [ROW_W-1:0] y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic [7:0]       color_q, color_d;
  logic             fb_we_q, fb_we_d;
  logic [AW-1:0]    fb_wa_q, fb_wa_d;
  logic [7:0]       fb_wd_q, fb_wd_d;
  logic             done_q, done_d, err_q, err_d, pulse_q, pulse_d;

  // Command decode. ABORT dominates START when both are set.
  logic cmd_wr, start, abort;
  assign cmd_wr = CFG_WE && (CFG_SEL == 2'd3);
  assign start  = cmd_wr && CFG_WD[0] && !CFG_WD[1];
  assign abort  = cmd_wr && CFG_WD[1];

  // Rectangle extents at 8 bits so x0+w / y0+h cannot wrap.
  logic [7:0] x_end, y_end, x_last, y_last;
  assign x_end  = 8'(x0_q) + 8'(w_q);
  assign y_end  = 8'(y0_q) + 8'(h_q);
  assign x_last = x_end - 8'd1;
  assign y_last = y_end - 8'd1;

  logic rect_ok, col_last, row_last;
  assign rect_ok  = (w_q != '0) && (h_q != '0) && (x_end <= H_LIM) && (y_end <= V_LIM);
  assign col_last = (8'(cx_q) == x_last);
  assign row_last = (8'(cy_q) == y_last);

  logic unused_cfg;
  assign unused_cfg = ^CFG_WD[31:14];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case/if tree leaves it unassigned, which would infer a latch.
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fb_we_d = 1'b0;
    fb_wa_d = fb_wa_q;
    fb_wd_d = fb_wd_q;
    done_d  = done_q;
    err_d   = err_q;
    pulse_d = 1'b0;

    // CPU writes own the port whenever they occur, in any state.
    if (CPU_WE) begin
      fb_we_d = 1'b1;
      fb_wa_d = CPU_WA;
      fb_wd_d = CPU_WD;
    end

    case (state_q)
      S_IDLE: begin
        // Geometry and colour are only writable while idle.
        if (CFG_WE) begin
          case (CFG_SEL)
            2'd0: begin
              x0_d = CFG_WD[COL_W-1:0];
              y0_d = CFG_WD[8 +: ROW_W];
            end
            2'd1: begin
              w_d = CFG_WD[COL_W-1:0];
              h_d = CFG_WD[8 +: ROW_W];
            end
            2'd2:    color_d = CFG_WD[7:0];
            default: ;
          endcase
        end
        if (start) begin
          done_d = 1'b0;
          if (rect_ok) begin
            err_d   = 1'b0;
            cx_d    = x0_q;
            cy_d    = y0_q;
            state_d = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!CPU_WE) begin
          // Engine owns the port this cycle; a CPU write stalls it instead.
          fb_we_d = 1'b1;
          fb_wa_d = {cy_q, cx_q};
          fb_wd_d = color_q;
          if (col_last) begin
            cx_d = x0_q;
            if (row_last) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              pulse_d = 1'b1;
            end else begin
              cy_d = cy_q + 1'b1;
            end
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      fb_we_q <= 1'b0;
      fb_wa_q <= '0;
      fb_wd_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      fb_we_q <= fb_we_d;
      fb_wa_q <= fb_wa_d;
      fb_wd_q <= fb_wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  assign FB_WE      = fb_we_q;
  assign FB_WA      = fb_wa_q;
  assign FB_WD      = fb_wd_q;
  assign BUSY       = (state_q == S_FILL);
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign DONE_PULSE = pulse_q;

endmodule
